// File: rtl/mem_pkg.sv
// Shared definitions for the march BIST controller and the small RAM blocks it tests.
package mem_pkg;

   localparam int MEM_ADDR_W = 2;
   localparam int MEM_DATA_W = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      W0   = 3'd1,
      R0   = 3'd2,
      W1   = 3'd3,
      R1   = 3'd4,
      FIN  = 3'd5
   } state_t;

endpackage

// File: rtl/mem_march_bist_if.sv
// RAM port bundle: the BIST drives address/data/write-enable, the RAM returns read data.
interface mem_march_bist_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4
) ();

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              mem_we;
   logic [DATA_W-1:0] mem_dout;

   modport master (
      output mem_addr,
      output mem_din,
      output mem_we,
      input  mem_dout
   );

   modport slave (
      input  mem_addr,
      input  mem_din,
      input  mem_we,
      output mem_dout
   );

endinterface

// File: rtl/mem_march_cmp.sv
// Read-data compare stage: delays the issued address and expected value by one cycle to line
// up with the RAM's registered read data, then tracks the first error and a saturating count.
module mem_march_cmp
   import mem_pkg::*;
#(
   parameter int ADDR_W   = MEM_ADDR_W,
   parameter int DATA_W   = MEM_DATA_W,
   parameter int ERRCNT_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                rd_issue,
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic [DATA_W-1:0]   rd_exp,
   input  logic [DATA_W-1:0]   mem_dout,
   output logic [ADDR_W-1:0]   err_addr,
   output logic [DATA_W-1:0]   err_data,
   output logic [ERRCNT_W-1:0] err_count,
   output logic                clean_next
);

   localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;

   logic              cmp_vld;
   logic [ADDR_W-1:0] cmp_addr;
   logic [DATA_W-1:0] cmp_exp;
   logic              mismatch;

   assign mismatch   = cmp_vld && (mem_dout != cmp_exp);
   // The counter saturates and never returns to zero mid-run, so zero means "no error yet".
   assign clean_next = (err_count == '0) && !mismatch;

   // Align the issued address and expected value with the read data that arrives a cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_vld  <= 1'b0;
         cmp_addr <= '0;
         cmp_exp  <= '0;
      end else begin
         cmp_vld  <= rd_issue;
         cmp_addr <= rd_addr;
         cmp_exp  <= rd_exp;
      end
   end

   // First-error capture and saturating mismatch counter, cleared at the start of each run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_addr  <= '0;
         err_data  <= '0;
         err_count <= '0;
      end else if (clr) begin
         err_addr  <= '0;
         err_data  <= '0;
         err_count <= '0;
      end else if (mismatch) begin
         if (err_count == '0) begin
            err_addr <= cmp_addr;
            err_data <= mem_dout;
         end
         if (err_count != CNT_MAX) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_march_bist.sv
// March BIST controller: writes P ascending, reads P ascending, writes ~P ascending,
// reads ~P descending, then reports the result with a one-cycle done pulse.
//
// state | meaning
// IDLE  | RAM port released (we=0); waiting for start
// W0    | write P to 0..N-1
// R0    | read 0..N-1 expecting P, plus one tail cycle to finish the last compare
// W1    | write ~P to 0..N-1
// R1    | read N-1..0 expecting ~P, plus one tail cycle
// FIN   | done pulse, pass latched
module mem_march_bist
   import mem_pkg::*;
#(
   parameter int                ADDR_W   = MEM_ADDR_W,
   parameter int                DATA_W   = MEM_DATA_W,
   parameter logic [DATA_W-1:0] PATTERN  = 4'b1010,
   parameter int                ERRCNT_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   mem_march_bist_if.master    mem,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ADDR_W-1:0]   err_addr,
   output logic [DATA_W-1:0]   err_data,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam logic [ADDR_W-1:0] LAST = '1;

   state_t            state;
   logic              rd_tail;
   logic              rd_issue;
   logic              run_clr;
   logic              clean_next;
   logic [DATA_W-1:0] rd_exp;

   assign rd_issue = ((state == R0) || (state == R1)) && !rd_tail;
   assign rd_exp   = (state == R0) ? PATTERN : ~PATTERN;
   assign run_clr  = (state == IDLE) && start;

   // Sequencer and address generation; every RAM-side and status output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rd_tail      <= 1'b0;
         mem.mem_addr <= '0;
         mem.mem_din  <= '0;
         mem.mem_we   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mem.mem_we <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
               if (start) begin
                  state        <= W0;
                  mem.mem_addr <= '0;
                  mem.mem_din  <= PATTERN;
                  mem.mem_we   <= 1'b1;
                  busy         <= 1'b1;
                  pass         <= 1'b0;
               end
            end
            W0: begin
               if (mem.mem_addr == LAST) begin
                  state        <= R0;
                  mem.mem_addr <= '0;
                  mem.mem_we   <= 1'b0;
               end else begin
                  mem.mem_addr <= mem.mem_addr + 1'b1;
               end
            end
            R0: begin
               if (!rd_tail) begin
                  if (mem.mem_addr == LAST) rd_tail <= 1'b1;
                  else mem.mem_addr <= mem.mem_addr + 1'b1;
               end else begin
                  rd_tail      <= 1'b0;
                  state        <= W1;
                  mem.mem_addr <= '0;
                  mem.mem_din  <= ~PATTERN;
                  mem.mem_we   <= 1'b1;
               end
            end
            W1: begin
               if (mem.mem_addr == LAST) begin
                  state        <= R1;
                  mem.mem_addr <= LAST;
                  mem.mem_we   <= 1'b0;
               end else begin
                  mem.mem_addr <= mem.mem_addr + 1'b1;
               end
            end
            R1: begin
               if (!rd_tail) begin
                  if (mem.mem_addr == '0) rd_tail <= 1'b1;
                  else mem.mem_addr <= mem.mem_addr - 1'b1;
               end else begin
                  // The last compare resolves in this cycle, so pass uses the look-ahead flag.
                  rd_tail <= 1'b0;
                  state   <= FIN;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= clean_next;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               rd_tail    <= 1'b0;
               mem.mem_we <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

   mem_march_cmp #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .ERRCNT_W(ERRCNT_W)
   ) u_cmp (
      .clk       (clk),
      .rst       (rst),
      .clr       (run_clr),
      .rd_issue  (rd_issue),
      .rd_addr   (mem.mem_addr),
      .rd_exp    (rd_exp),
      .mem_dout  (mem.mem_dout),
      .err_addr  (err_addr),
      .err_data  (err_data),
      .err_count (err_count),
      .clean_next(clean_next)
   );

endmodule

// File: tb/tb_mem_march_bist.sv
// Directed bench: two BIST instances (4-bit and 2-bit error counters) each driving a 4x4 RAM
// model with selectable faults; expected values are hand-computed constants.
module tb_mem_march_bist;

   logic clk;
   logic rst;
   logic start;

   logic       busy, done, pass;
   logic [1:0] err_addr;
   logic [3:0] err_data;
   logic [3:0] err_count;

   logic       s_busy, s_done, s_pass;
   logic [1:0] s_err_addr;
   logic [3:0] s_err_data;
   logic [1:0] s_err_count;

   // 0 = fault-free, 1 = bit0 stuck-at-1 at addr 2, 2 = every word reads 1111
   int fault_mode;

   int n_cmp;
   int n_bad;

   logic [3:0] ram0 [4];
   logic [3:0] ram1 [4];

   mem_march_bist_if #(.ADDR_W(2), .DATA_W(4)) bus ();
   mem_march_bist_if #(.ADDR_W(2), .DATA_W(4)) bus_s ();

   mem_march_bist #(.ADDR_W(2), .DATA_W(4), .PATTERN(4'b1010), .ERRCNT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mem      (bus),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_addr (err_addr),
      .err_data (err_data),
      .err_count(err_count)
   );

   mem_march_bist #(.ADDR_W(2), .DATA_W(4), .PATTERN(4'b1010), .ERRCNT_W(2)) dut_sat (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mem      (bus_s),
      .busy     (s_busy),
      .done     (s_done),
      .pass     (s_pass),
      .err_addr (s_err_addr),
      .err_data (s_err_data),
      .err_count(s_err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] faulty(input logic [1:0] a, input logic [3:0] d);
      if (fault_mode == 1 && a == 2'd2) return d | 4'b0001;
      if (fault_mode == 2) return 4'b1111;
      return d;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_we) ram0[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= faulty(bus.mem_addr, ram0[bus.mem_addr]);
   end

   always @(posedge clk) begin
      if (bus_s.mem_we) ram1[bus_s.mem_addr] <= bus_s.mem_din;
      bus_s.mem_dout <= faulty(bus_s.mem_addr, ram1[bus_s.mem_addr]);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts a run from IDLE; returns at the done cycle (or after a bounded wait).
   // pulse_at re-asserts start for one cycle at that busy cycle; hold keeps start high.
   task automatic run_test(input int pulse_at, input bit hold,
                           output int busy_cyc, output int done_at, output int seq_bad);
      int exp_addr [18] = '{0,1,2,3, 0,1,2,3,3, 0,1,2,3, 3,2,1,0,0};
      int exp_we   [18] = '{1,1,1,1, 0,0,0,0,0, 1,1,1,1, 0,0,0,0,0};
      busy_cyc = 0;
      done_at  = 0;
      seq_bad  = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 40; c++) begin
         if (busy) busy_cyc++;
         if (c <= 18) begin
            if (int'(bus.mem_addr) != exp_addr[c-1]) seq_bad++;
            if (int'(bus.mem_we) != exp_we[c-1]) seq_bad++;
            if (bus.mem_we && bus.mem_din != ((c <= 4) ? 4'b1010 : 4'b0101)) seq_bad++;
         end
         if (done) begin
            done_at = c;
            break;
         end
         if (c == pulse_at) start = 1'b1;
         else if (!hold) start = 1'b0;
         @(negedge clk);
      end
   endtask

   int bc, da, sb;
   int n_done, n_busy;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      fault_mode = 0;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_pass", pass, 0);
      check_val("rst_we", bus.mem_we, 0);
      check_val("rst_addr", bus.mem_addr, 0);
      check_val("rst_errcnt", err_count, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Fault-free run with a stray start pulse in W1 (cycle 10).
      run_test(10, 1'b0, bc, da, sb);
      check_val("clean_busy_cycles", bc, 18);
      check_val("clean_done_cycle", da, 19);
      check_val("clean_sequence", sb, 0);
      check_val("clean_pass", pass, 1);
      check_val("clean_errcnt", err_count, 0);
      check_val("clean_erraddr", err_addr, 0);
      check_val("clean_errdata", err_data, 0);
      for (int i = 0; i < 4; i++) check_val("clean_ram", ram0[i], 4'b0101);
      @(negedge clk);
      check_val("done_pulse_width", done, 0);
      check_val("pass_holds", pass, 1);

      // Bit 0 stuck-at-1 at address 2.
      fault_mode = 1;
      run_test(0, 1'b0, bc, da, sb);
      check_val("stuck_done_cycle", da, 19);
      check_val("stuck_errcnt", err_count, 1);
      check_val("stuck_erraddr", err_addr, 2);
      check_val("stuck_errdata", err_data, 4'b1011);
      check_val("stuck_pass", pass, 0);

      // Every word reads 1111; second instance saturates its 2-bit counter.
      fault_mode = 2;
      run_test(0, 1'b0, bc, da, sb);
      check_val("all_done_cycle", da, 19);
      check_val("all_errcnt", err_count, 8);
      check_val("all_erraddr", err_addr, 0);
      check_val("all_errdata", err_data, 4'b1111);
      check_val("all_pass", pass, 0);
      check_val("sat_errcnt", s_err_count, 3);
      check_val("sat_pass", s_pass, 0);
      check_val("sat_done", s_done, 1);

      // Reset asserted in the second cycle of R0.
      fault_mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check_val("r0c2_addr", bus.mem_addr, 1);
      rst = 1'b1;
      #1;
      check_val("midrst_we", bus.mem_we, 0);
      check_val("midrst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      n_busy = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) n_done++;
         if (busy) n_busy++;
      end
      check_val("midrst_no_done", n_done, 0);
      check_val("midrst_no_busy", n_busy, 0);
      run_test(0, 1'b0, bc, da, sb);
      check_val("after_rst_busy_cycles", bc, 18);
      check_val("after_rst_sequence", sb, 0);
      check_val("after_rst_pass", pass, 1);

      // Start held high: back-to-back runs.
      run_test(0, 1'b1, bc, da, sb);
      check_val("held_done_cycle", da, 19);
      check_val("held_pass1", pass, 1);
      @(negedge clk);
      check_val("held_gap_busy", busy, 0);
      check_val("held_pass_kept", pass, 1);
      @(negedge clk);
      check_val("held_run2_busy", busy, 1);
      check_val("held_run2_pass_clr", pass, 0);
      check_val("held_run2_we", bus.mem_we, 1);
      start = 1'b0;
      da = 0;
      for (int c = 2; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            da = c;
            break;
         end
      end
      check_val("held_run2_done_cycle", da, 19);
      check_val("held_run2_pass", pass, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
